// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: one Booth group is retired per clock into a
// 2N-bit accumulator. Handles signed or unsigned operands, chosen per operation.
module booth_mult_seq #(
  parameter int N = 32,
  parameter int P = 2 * N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_tc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [P-1:0] out_p,
  output logic         busy,
  output logic [1:0]   o_dbg_state
);

  localparam int NG = N / 2 + 1;
  localparam int CW = $clog2(NG);
  localparam logic [CW-1:0] LAST_GRP = CW'(NG - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high. The producer keeps valid and data steady until that edge; ready never
  // depends on valid in the same cycle.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [P-1:0]    r_mcand;
  logic [N+2:0]    r_y;
  logic [P-1:0]    r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;

  logic [N:0]      w_a_ext;
  logic            w_e;
  logic            w_one;
  logic            w_two;
  logic            w_neg;
  logic [P-1:0]    w_mag;
  logic [P-1:0]    w_addend;
  logic [P-1:0]    w_acc_nxt;

  assign w_a_ext = {in_tc & in_a[N-1], in_a};
  assign w_e     = in_tc & in_b[N-1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == LAST_GRP) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_BUSY);
    end
  end

  // The low triplet of the shifting multiplier register selects the Booth digit.
  always_comb begin
    w_one = 1'b0;
    w_two = 1'b0;
    w_neg = 1'b0;
    case (r_y[2:0])
      3'b001, 3'b010: w_one = 1'b1;
      3'b011:         w_two = 1'b1;
      3'b100:         begin w_two = 1'b1; w_neg = 1'b1; end
      3'b101, 3'b110: begin w_one = 1'b1; w_neg = 1'b1; end
      default:        ;
    endcase
  end

  always_comb begin
    w_mag = '0;
    if (w_two)      w_mag = {r_mcand[P-2:0], 1'b0};
    else if (w_one) w_mag = r_mcand;
  end

  // Negation as invert plus carry-in keeps a single adder.
  assign w_addend  = w_neg ? ~w_mag : w_mag;
  assign w_acc_nxt = r_acc + w_addend + {{(P-1){1'b0}}, w_neg};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_y     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand <= {{(P-N-1){w_a_ext[N]}}, w_a_ext};
            r_y     <= {w_e, w_e, in_b, 1'b0};
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        S_BUSY: begin
          r_acc   <= w_acc_nxt;
          r_mcand <= {r_mcand[P-3:0], 2'b00};
          r_y     <= {{2{r_y[N+2]}}, r_y[N+2:2]};
          r_cnt   <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign out_p       = r_acc;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq at N = 4, 8 and 32, checked against a plain-arithmetic
// product model with a per-operation latency check.
module tb_booth_mult_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  in_valid;
  logic [2:0]  in_tc;
  logic [2:0]  out_ready;
  wire  [2:0]  in_ready;
  wire  [2:0]  out_valid;
  wire  [2:0]  busy;
  logic [31:0] a_drv [3];
  logic [31:0] b_drv [3];
  wire  [7:0]  p4;
  wire  [15:0] p8;
  wire  [63:0] p32;
  wire  [1:0]  st4, st8, st32;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q [$];

  booth_mult_seq #(.N(4)) u_n4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(a_drv[0][3:0]), .in_b(b_drv[0][3:0]), .in_tc(in_tc[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_p(p4),
    .busy(busy[0]), .o_dbg_state(st4)
  );

  booth_mult_seq #(.N(8)) u_n8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(a_drv[1][7:0]), .in_b(b_drv[1][7:0]), .in_tc(in_tc[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_p(p8),
    .busy(busy[1]), .o_dbg_state(st8)
  );

  booth_mult_seq #(.N(32)) u_n32 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(a_drv[2]), .in_b(b_drv[2]), .in_tc(in_tc[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_p(p32),
    .busy(busy[2]), .o_dbg_state(st32)
  );

  function automatic int width_of(input int d);
    case (d)
      0:       return 4;
      1:       return 8;
      default: return 32;
    endcase
  endfunction

  function automatic int ng_of(input int d);
    return width_of(d) / 2 + 1;
  endfunction

  function automatic logic [63:0] p_of(input int d);
    case (d)
      0:       return {56'd0, p4};
      1:       return {48'd0, p8};
      default: return p32;
    endcase
  endfunction

  function automatic logic [1:0] st_of(input int d);
    case (d)
      0:       return st4;
      1:       return st8;
      default: return st32;
    endcase
  endfunction

  // Reference: interpret the operands at width w, multiply, keep 2w bits.
  function automatic logic [63:0] ref_prod(input int d, input logic [31:0] a,
                                           input logic [31:0] b, input logic tc);
    int w;
    logic [63:0] ua, ub, mask, full;
    longint sa, sb;
    w    = width_of(d);
    ua   = {32'd0, a} & ((64'd1 << w) - 64'd1);
    ub   = {32'd0, b} & ((64'd1 << w) - 64'd1);
    mask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
    if (tc) begin
      sa = longint'(ua);
      sb = longint'(ub);
      if (ua[w-1]) sa = sa - longint'(64'd1 << w);
      if (ub[w-1]) sb = sb - longint'(64'd1 << w);
      full = 64'(sa * sb);
    end else begin
      full = ua * ub;
    end
    return full & mask;
  endfunction

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_tc[d]     = 1'b0;
      out_ready[d] = 1'b1;
      a_drv[d]     = '0;
      b_drv[d]     = '0;
    end
  endtask

  // One operation with out_ready high; checks busy, latency and product.
  task automatic run_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input logic tc, input logic [63:0] exp_p, input string name);
    int guard;
    int lat;
    bit seen;
    logic [63:0] want;
    guard = 0;
    while (!in_ready[d] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (in_ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL %s ready: in_ready=%b required 1", name, in_ready[d]);
    end
    a_drv[d] = a; b_drv[d] = b; in_tc[d] = tc;
    in_valid[d] = 1'b1; out_ready[d] = 1'b1;
    exp_q.push_back(exp_p);
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    a_drv[d] = $urandom; b_drv[d] = $urandom; in_tc[d] = 1'($urandom_range(0, 1));
    lat = 0; seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        checks++;
        if (busy[d] !== 1'b1) begin
          errors++;
          $display("FAIL %s busy: busy=%b required 1", name, busy[d]);
        end
      end
      if (out_valid[d] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (lat != ng_of(d) + 1) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles required %0d", name, lat, ng_of(d) + 1);
    end
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    checks++;
    if (p_of(d) !== want) begin
      errors++;
      $display("FAIL %s product: out_p=%h required %h", name, p_of(d), want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks += 5;
      if (in_ready[d] !== 1'b1) begin
        errors++; $display("FAIL reset_in_ready[%0d]: %b required 1", d, in_ready[d]);
      end
      if (out_valid[d] !== 1'b0) begin
        errors++; $display("FAIL reset_out_valid[%0d]: %b required 0", d, out_valid[d]);
      end
      if (busy[d] !== 1'b0) begin
        errors++; $display("FAIL reset_busy[%0d]: %b required 0", d, busy[d]);
      end
      if (p_of(d) !== 64'd0) begin
        errors++; $display("FAIL reset_out_p[%0d]: %h required 0", d, p_of(d));
      end
      if (st_of(d) !== 2'd0) begin
        errors++; $display("FAIL reset_state[%0d]: %0d required 0", d, st_of(d));
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(1, 32'h80, 32'h80, 1'b1, 64'h4000, "n8_s_min_sq");
    run_op(1, 32'hFF, 32'hFF, 1'b0, 64'hFE01, "n8_u_ff_ff");
    run_op(1, 32'hFF, 32'hFF, 1'b1, 64'h0001, "n8_s_ff_ff");
    run_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "n32_u_max");
    run_op(2, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, "n32_s_mix");
    run_op(0, 32'h8, 32'h8, 1'b1, 64'h40, "n4_s_min_sq");
    run_op(0, 32'hF, 32'hF, 1'b0, 64'hE1, "n4_u_max");
  endtask

  task automatic test_backpressure();
    int guard;
    a_drv[1] = 32'h12; b_drv[1] = 32'h34; in_tc[1] = 1'b0;
    in_valid[1] = 1'b1; out_ready[1] = 1'b0;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    guard = 0;
    while (out_valid[1] !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (out_valid[1] !== 1'b1) begin
      errors++; $display("FAIL bp_wait: out_valid=%b required 1 within 40 cycles", out_valid[1]);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a_drv[1] = $urandom; b_drv[1] = $urandom;
      in_tc[1] = 1'($urandom_range(0, 1)); in_valid[1] = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks += 3;
      if (out_valid[1] !== 1'b1) begin
        errors++; $display("FAIL bp_hold_valid[%0d]: %b required 1", i, out_valid[1]);
      end
      if (p8 !== 16'h03A8) begin
        errors++; $display("FAIL bp_hold_p[%0d]: %h required 03a8", i, p8);
      end
      if (in_ready[1] !== 1'b0) begin
        errors++; $display("FAIL bp_hold_ready[%0d]: %b required 0", i, in_ready[1]);
      end
    end
    // Release with in_valid high: the DONE->IDLE edge must not accept.
    in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    @(negedge clk);
    checks += 3;
    if (in_ready[1] !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: %b required 1", in_ready[1]);
    end
    if (busy[1] !== 1'b0) begin
      errors++; $display("FAIL bp_release_no_accept: busy=%b required 0", busy[1]);
    end
    if (out_valid[1] !== 1'b0) begin
      errors++; $display("FAIL bp_release_valid: %b required 0", out_valid[1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int spurious;
    a_drv[1] = 32'd5; b_drv[1] = 32'd7; in_tc[1] = 1'b0;
    in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks += 4;
    if (in_ready[1] !== 1'b1) begin
      errors++; $display("FAIL midrst_ready: %b required 1", in_ready[1]);
    end
    if (out_valid[1] !== 1'b0) begin
      errors++; $display("FAIL midrst_valid: %b required 0", out_valid[1]);
    end
    if (busy[1] !== 1'b0) begin
      errors++; $display("FAIL midrst_busy: %b required 0", busy[1]);
    end
    if (p8 !== 16'h0000) begin
      errors++; $display("FAIL midrst_p: %h required 0000", p8);
    end
    spurious = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid[1] === 1'b1) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++; $display("FAIL midrst_no_emit: %0d out_valid cycles required 0", spurious);
    end
    run_op(1, 32'h03, 32'hFE, 1'b1, 64'hFFFA, "n8_after_rst");

    // Reset while holding a finished product under back-pressure.
    a_drv[0] = 32'h7; b_drv[0] = 32'h3; in_tc[0] = 1'b0;
    in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks += 3;
    if (out_valid[0] !== 1'b0) begin
      errors++; $display("FAIL donerst_valid: %b required 0", out_valid[0]);
    end
    if (p4 !== 8'h00) begin
      errors++; $display("FAIL donerst_p: %h required 00", p4);
    end
    if (in_ready[0] !== 1'b1) begin
      errors++; $display("FAIL donerst_ready: %b required 1", in_ready[0]);
    end
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc, last, accepts, guard;
    bit acc;
    logic [63:0] want;
    cyc = 0; last = -1; accepts = 0;
    a_drv[1] = $urandom; b_drv[1] = $urandom; in_tc[1] = 1'($urandom_range(0, 1));
    in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    while (accepts < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (out_valid[1] === 1'b1) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        checks++;
        if ({48'd0, p8} !== want) begin
          errors++; $display("FAIL b2b_product: out_p=%h required %h", p8, want);
        end
      end
      acc = (in_ready[1] === 1'b1);
      if (acc) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != ng_of(1) + 2) begin
            errors++;
            $display("FAIL b2b_interval: %0d cycles required %0d", cyc - last, ng_of(1) + 2);
          end
        end
        last = cyc;
        exp_q.push_back(ref_prod(1, a_drv[1], b_drv[1], in_tc[1]));
        accepts++;
      end
      @(posedge clk); #1;
      if (acc) begin
        a_drv[1] = $urandom; b_drv[1] = $urandom; in_tc[1] = 1'($urandom_range(0, 1));
        if (accepts == 3) in_valid[1] = 1'b0;
      end
    end
    guard = 0;
    while (exp_q.size() > 0 && guard < 40) begin
      @(negedge clk);
      guard++;
      if (out_valid[1] === 1'b1) begin
        want = exp_q.pop_front();
        checks++;
        if ({48'd0, p8} !== want) begin
          errors++; $display("FAIL b2b_drain_product: out_p=%h required %h", p8, want);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || accepts != 3) begin
      errors++;
      $display("FAIL b2b_complete: pending=%0d accepts=%0d required 0 and 3", exp_q.size(), accepts);
    end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic tc;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 300; i++) begin
        a  = $urandom;
        b  = $urandom;
        tc = 1'($urandom_range(0, 1));
        if (i < 4) begin
          a = (i[0]) ? 32'hFFFF_FFFF : 32'd0;
          b = (i[1]) ? 32'hFFFF_FFFF : 32'd0;
        end
        run_op(d, a, b, tc, ref_prod(d, a, b, tc), $sformatf("rand_n%0d_%0d", width_of(d), i));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
